fconv_unit: RTL and testbench

Pipelined floating-point width converter for the CPU's conversion path. It executes `f32.demote_f64` and `f64.promote_f32` with IEEE-754 round-to-nearest-even, subnormal support, overflow-to-infinity and NaN canonicalisation. It accepts one operation per cycle over a valid/ready handshake and returns tagged results with the operand-stack type code. It replaces the single-op, fixed-latency demote path with a parametrised, back-pressurable, bidirectional unit.

---
 rtl/fconv_pkg.sv | 46 ++++
 rtl/fconv_round_rne.sv | 46 ++++
 rtl/fconv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_fconv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fconv_pkg.sv
// fconv_pkg: shared constants and types for the f32/f64 width converter.
//   - operand-stack type codes (mirroring cpu.vh)
//   - op encodings, exponent bias delta, canonical NaN patterns
//   - flag bit indices within out_flags = {invalid, overflow, underflow, inexact}
//   - the unpacked operand record carried between pipeline stages
package fconv_pkg;

  // Operand-stack type codes, kept in step with cpu.vh.
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  localparam logic FCONV_DEMOTE  = 1'b0;
  localparam logic FCONV_PROMOTE = 1'b1;

  // f64 bias (1023) minus f32 bias (127).
  localparam logic [10:0] BIAS_DELTA = 11'd896;

  localparam logic [31:0] CANON_NAN_F32 = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN_F64 = 64'h7FF8_0000_0000_0000;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  typedef enum logic [1:0] {
    CLS_FIN,   // zero, subnormal or normal
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } cls_t;

  // Unpacked operand. For demote, mant is the 53-bit significand and shamt the
  // total right shift down to the 24-bit f32 significand; exp is the rebiased
  // f32 exponent, 0 when the result is subnormal. For promote, exp/mant already
  // hold the final f64 exponent and fraction (mant[51:0]).
  typedef struct packed {
    logic        op;
    logic        sign;
    cls_t        cls;
    logic [12:0] exp;
    logic [52:0] mant;
    logic [5:0]  shamt;
  } stage_t;

endpackage

// File: rtl/fconv_round_rne.sv
// fconv_round_rne: combinational right shifter and round-to-nearest-even.
//   mant    in  IN_W   significand to be shifted down
//   shamt   in  SH_W   total right shift amount
//   result  out OUT_W  rounded, shifted significand
//   carry   out 1      rounding overflowed out of OUT_W bits
//   inexact out 1      any nonzero bit was shifted out
module fconv_round_rne #(
  parameter int IN_W  = 53,
  parameter int OUT_W = 24,
  parameter int SH_W  = 6
) (
  input  logic [IN_W-1:0]  mant,
  input  logic [SH_W-1:0]  shamt,
  output logic [OUT_W-1:0] result,
  output logic             carry,
  output logic             inexact
);

  logic [IN_W+1:0]  wide;
  logic [IN_W+1:0]  lost_mask;
  logic [OUT_W+1:0] kept_gr;
  logic             guard;
  logic             round_bit;
  logic             sticky;
  logic             round_up;
  logic [OUT_W:0]   sum;

  // Two zero bits appended below the LSB let guard and round fall out of the
  // same shift as the kept bits; everything below them collapses into sticky.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a value on
    // every path, otherwise synthesis infers a latch to hold the old value.
    wide      = {mant, 2'b00};
    kept_gr   = (OUT_W+2)'(wide >> shamt);
    lost_mask = ~({(IN_W+2){1'b1}} << shamt);
    guard     = kept_gr[1];
    round_bit = kept_gr[0];
    sticky    = |(wide & lost_mask);
    round_up  = guard & (round_bit | sticky | kept_gr[2]);
    sum       = {1'b0, kept_gr[OUT_W+1:2]} + {{OUT_W{1'b0}}, round_up};
    result    = sum[OUT_W-1:0];
    carry     = sum[OUT_W];
    inexact   = guard | round_bit | sticky;
  end

endmodule

// File: rtl/fconv_unit.sv
// fconv_unit: pipelined f64->f32 demote / f32->f64 promote, RNE rounding.
//   clk, reset_n                   clock, async active-low reset
//   in_valid/in_ready              operand handshake
//   in_op, in_data, in_tag         0 = demote, 1 = promote; operand; sideband tag
//   out_valid/out_ready            result handshake
//   out_data, out_type, out_tag    result (f32 in [31:0]), type code, tag
//   out_flags                      {invalid, overflow, underflow, inexact}
// Stage 1 unpacks/rebiases, optional retiming stages follow, the last stage
// rounds and packs into the output registers. The pipe stalls as a whole.
module fconv_unit
  import fconv_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter bit CANON_NAN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [1:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- unpack / classify / rebias ----------------
  stage_t             front;
  logic [10:0]        d_exp;
  logic [51:0]        d_frac;
  logic signed [12:0] d_reb;
  logic [12:0]        d_den;
  logic [7:0]         p_exp;
  logic [22:0]        p_frac;
  logic [22:0]        p_norm;
  logic [4:0]         p_lz;

  always_comb begin
    front  = '0;
    d_exp  = in_data[62:52];
    d_frac = in_data[51:0];
    d_reb  = '0;
    d_den  = '0;
    p_exp  = in_data[30:23];
    p_frac = in_data[22:0];
    p_lz   = '0;
    for (int i = 0; i < 23; i++) begin
      if (p_frac[i]) p_lz = 5'(22 - i);
    end
    p_norm   = p_frac << (p_lz + 5'd1);
    front.op = in_op;

    if (in_op == FCONV_DEMOTE) begin
      front.sign = in_data[63];
      if (d_exp == 11'h7FF) begin
        front.mant = {1'b0, d_frac};
        front.cls  = (d_frac == '0) ? CLS_INF : (d_frac[51] ? CLS_QNAN : CLS_SNAN);
      end else begin
        // f64 subnormals share the exponent of the smallest normal.
        front.mant = {d_exp != 11'd0, d_frac};
        d_reb = $signed({2'b00, (d_exp == 11'd0) ? 11'd1 : d_exp})
              - $signed({2'b00, BIAS_DELTA});
        if (d_reb > 13'sd0) begin
          front.exp   = 13'(d_reb);
          front.shamt = 6'd29;
        end else begin
          // Tiny result: extra denormalising shift, saturated at 25 where
          // every significand bit already lands below the round position.
          d_den       = 13'(13'sd1 - d_reb);
          front.shamt = (d_den > 13'd25) ? 6'd54 : 6'd29 + d_den[5:0];
        end
      end
    end else begin
      front.sign = in_data[31];
      if (p_exp == 8'hFF) begin
        front.mant = {1'b0, p_frac, 29'b0};
        front.cls  = (p_frac == '0) ? CLS_INF : (p_frac[22] ? CLS_QNAN : CLS_SNAN);
      end else if (p_exp != 8'd0) begin
        front.exp  = {2'b00, {3'b000, p_exp} + BIAS_DELTA};
        front.mant = {1'b1, p_frac, 29'b0};
      end else if (p_frac != '0) begin
        // Normalise: leading one moves to the hidden position and drops out.
        front.exp  = {2'b00, BIAS_DELTA - {6'b0, p_lz}};
        front.mant = {1'b1, p_norm, 29'b0};
      end
    end
  end

  // ---------------- stage registers ----------------
  stage_t             pk_in;
  logic [TAG_W-1:0]   pk_tag;
  logic               pk_v;

  if (PIPE_DEPTH == 1) begin : g_direct
    assign pk_in  = front;
    assign pk_tag = in_tag;
    assign pk_v   = in_valid;
  end else begin : g_stages
    localparam int N = PIPE_DEPTH - 1;
    stage_t           stg_q [N];
    logic [TAG_W-1:0] tag_q [N];
    logic [N-1:0]     vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the clock edge.
      if (!reset_n) begin
        vld_q <= '0;
      end else if (advance) begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < N; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    // NOTE: payload registers are deliberately left without reset; the valid
    // bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
      if (advance) begin
        stg_q[0] <= front;
        tag_q[0] <= in_tag;
        for (int i = 1; i < N; i++) begin
          stg_q[i] <= stg_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end

    assign pk_in  = stg_q[N-1];
    assign pk_tag = tag_q[N-1];
    assign pk_v   = vld_q[N-1];
  end

  // ---------------- round and pack ----------------
  logic [23:0] rnd_res;
  logic        rnd_carry;
  logic        rnd_inexact;
  logic [12:0] exp_sum;
  logic [63:0] pk_data;
  logic [1:0]  pk_type;
  logic [3:0]  pk_flags;

  fconv_round_rne #(.IN_W(53), .OUT_W(24), .SH_W(6)) u_round (
    .mant    (pk_in.mant),
    .shamt   (pk_in.shamt),
    .result  (rnd_res),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  always_comb begin
    pk_data  = '0;
    pk_flags = '0;
    pk_type  = TYPE_F64;
    exp_sum  = pk_in.exp + {12'b0, rnd_carry};
    if (pk_in.op == FCONV_DEMOTE) begin
      pk_type = TYPE_F32;
      case (pk_in.cls)
        CLS_INF: pk_data[31:0] = {pk_in.sign, 8'hFF, 23'b0};
        CLS_QNAN, CLS_SNAN: begin
          pk_data[31:0]     = CANON_NAN ? CANON_NAN_F32
                                        : {pk_in.sign, 8'hFF, 1'b1, pk_in.mant[50:29]};
          pk_flags[FLAG_NV] = (pk_in.cls == CLS_SNAN);
        end
        default: begin
          if (pk_in.exp == '0) begin
            // Subnormal path: a round-up into bit 23 yields the smallest normal.
            pk_data[31:0]     = {pk_in.sign, 7'b0, rnd_res};
            pk_flags[FLAG_UF] = rnd_inexact;
            pk_flags[FLAG_NX] = rnd_inexact;
          end else if (exp_sum >= 13'd255) begin
            pk_data[31:0]     = {pk_in.sign, 8'hFF, 23'b0};
            pk_flags[FLAG_OF] = 1'b1;
            pk_flags[FLAG_NX] = 1'b1;
          end else begin
            pk_data[31:0]     = {pk_in.sign, exp_sum[7:0], rnd_res[22:0]};
            pk_flags[FLAG_NX] = rnd_inexact;
          end
        end
      endcase
    end else begin
      case (pk_in.cls)
        CLS_INF: pk_data = {pk_in.sign, 11'h7FF, 52'b0};
        CLS_QNAN, CLS_SNAN: begin
          pk_data           = CANON_NAN ? CANON_NAN_F64
                                        : {pk_in.sign, 11'h7FF, 1'b1, pk_in.mant[50:0]};
          pk_flags[FLAG_NV] = (pk_in.cls == CLS_SNAN);
        end
        default: pk_data = {pk_in.sign, pk_in.exp[10:0], pk_in.mant[51:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_type  <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (advance) begin
      out_valid <= pk_v;
      if (pk_v) begin
        out_data  <= pk_data;
        out_type  <= pk_type;
        out_tag   <= pk_tag;
        out_flags <= pk_flags;
      end
    end
  end

endmodule

// File: tb/tb_fconv_unit.sv
// tb_fconv_unit: self-checking bench for fconv_unit. Stimulus is drawn from a
// table of operands with hand-derived results; each accepted op pushes its
// expected result to a scoreboard that a negedge monitor compares and pops.
module tb_fconv_unit;
  import fconv_pkg::*;

  localparam int PIPE_DEPTH = 2;
  localparam int TAG_W      = 4;

  typedef struct {
    logic [63:0]      data;
    logic [1:0]       typ;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_op = 1'b0;
  logic [63:0]      in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [63:0]      out_data;
  logic [1:0]       out_type;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_exp;
  bit   b2b_done;

  fconv_unit #(.PIPE_DEPTH(PIPE_DEPTH), .TAG_W(TAG_W), .CANON_NAN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_type  (out_type),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // {op, operand, expected result, expected flags{NV,OF,UF,NX}}
  function automatic logic [132:0] vec(input int i);
    case (i)
      0:  vec = {1'b0, 64'hC000_0000_0000_0000, 64'h0000_0000_C000_0000, 4'b0000};
      1:  vec = {1'b0, 64'h3FF0_0000_1000_0000, 64'h0000_0000_3F80_0000, 4'b0001};
      2:  vec = {1'b0, 64'h3FF0_0000_3000_0000, 64'h0000_0000_3F80_0002, 4'b0001};
      3:  vec = {1'b0, 64'h47F0_0000_0000_0000, 64'h0000_0000_7F80_0000, 4'b0101};
      4:  vec = {1'b0, 64'h36A0_0000_0000_0000, 64'h0000_0000_0000_0001, 4'b0000};
      5:  vec = {1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 4'b0011};
      6:  vec = {1'b0, 64'h7FF0_0000_0000_0001, 64'h0000_0000_7FC0_0000, 4'b1000};
      7:  vec = {1'b0, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 4'b0000};
      8:  vec = {1'b1, 64'h0000_0000_3F80_0000, 64'h3FF0_0000_0000_0000, 4'b0000};
      9:  vec = {1'b1, 64'h0000_0000_0000_0001, 64'h36A0_0000_0000_0000, 4'b0000};
      10: vec = {1'b1, 64'h0000_0000_7F80_0001, 64'h7FF8_0000_0000_0000, 4'b1000};
      11: vec = {1'b1, 64'hDEAD_BEEF_FF80_0000, 64'hFFF0_0000_0000_0000, 4'b0000};
      12: vec = {1'b0, 64'h3FEF_FFFF_FFFF_FFFF, 64'h0000_0000_3F80_0000, 4'b0001};
      13: vec = {1'b0, 64'h47EF_FFFF_F000_0000, 64'h0000_0000_7F80_0000, 4'b0101};
      default: vec = '0;
    endcase
  endfunction

  // Result monitor: compares whatever is presented against the scoreboard
  // head, every cycle it is presented, so stalled outputs must hold.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%h tag=%h, required none", out_data, out_tag);
      end else begin
        mon_exp = sb[0];
        if ({out_data, out_type, out_tag, out_flags} !==
            {mon_exp.data, mon_exp.typ, mon_exp.tag, mon_exp.flags}) begin
          n_fail++;
          $display("FAIL result: got data=%h type=%0d tag=%h flags=%b, required data=%h type=%0d tag=%h flags=%b",
                   out_data, out_type, out_tag, out_flags,
                   mon_exp.data, mon_exp.typ, mon_exp.tag, mon_exp.flags);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one op, wait (bounded) for acceptance, push its expected result.
  // Returns 1 time unit after the accepting edge.
  task automatic send(input int vi, input logic [TAG_W-1:0] tag);
    logic [132:0] v;
    exp_t         e;
    int           waited;
    v        = vec(vi);
    in_valid = 1'b1;
    in_op    = v[132];
    in_data  = v[131:68];
    in_tag   = tag;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: vec %0d not accepted after %0d cycles", vi, waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.data  = v[67:4];
      e.typ   = v[132] ? TYPE_F64 : TYPE_F32;
      e.tag   = tag;
      e.flags = v[3:0];
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 500) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results pending after %0d cycles, required 0", sb.size(), cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({out_valid, out_data, out_type, out_tag, out_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h type=%0d tag=%h flags=%b, required all 0",
               out_valid, out_data, out_type, out_tag, out_flags);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_demote_latency();
    int lat;
    out_ready = 1'b1;
    send(0, 4'h3);
    // The accept cycle counts as cycle 0; we are now inside cycle 1.
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat != PIPE_DEPTH) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, PIPE_DEPTH);
    end
    wait_drain();
  endtask

  task automatic test_demote_round();
    send(1, 4'h1);
    send(2, 4'h2);
    send(12, 4'hC);
    wait_drain();
  endtask

  task automatic test_demote_boundary();
    send(3, 4'h3);
    send(13, 4'hD);
    send(4, 4'h4);
    send(5, 4'h5);
    send(6, 4'h6);
    send(7, 4'h7);
    wait_drain();
  endtask

  task automatic test_promote();
    for (int i = 8; i <= 11; i++) send(i, 4'(i));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int order [8] = '{2, 9, 3, 10, 5, 8, 13, 11};
    b2b_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(order[i], 4'(i + 1));
        wait_drain();
        b2b_done = 1'b1;
      end
      begin
        while (!b2b_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic test_reset_inflight();
    int  cyc;
    bit  stale;
    out_ready = 1'b0;
    send(1, 4'hA);
    send(8, 4'hB);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL prefill: got out_valid=%b, required 1", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_tag, out_flags} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=%h tag=%h flags=%b, required all 0",
               out_valid, out_data, out_tag, out_flags);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    stale     = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_tests++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got out_valid high after release, required none");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_demote_latency();
    test_demote_round();
    test_demote_boundary();
    test_promote();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
